gnt_lock_mux: RTL and testbench

- Downstream consumer of the one-hot grant produced by the fixed-priority and round-robin arbiters.
- Presents per-port valid requests to an external combinational arbiter and latches the returned one-hot grant.
- Holds that grant for a whole multi-beat packet, terminated by `last`, and steers the selected port's data through a registered valid/ready output stage.
- Sits between N requester queues and a single shared downstream channel.

---
 rtl/gnt_lock_mux_if.sv | 32 +++
 rtl/gnt_lock_mux.sv | 106 ++++++++++
 tb/tb_gnt_lock_mux.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gnt_lock_mux_if.sv
// Port bundle for gnt_lock_mux: requester side, arbiter loop, and the shared output channel.
// The master modport is the mux itself; slave is the surrounding requesters, arbiter and sink.
interface gnt_lock_mux_if #(
    parameter int N = 8,
    parameter int W = 32
);
    localparam int SW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   arb_req;
    logic [N-1:0]   arb_gnt;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_src;
    logic           out_ready;
    logic           err_gnt;
    logic [15:0]    pkt_cnt;

    modport master (
        input  in_valid, in_data, in_last, arb_gnt, out_ready,
        output in_ready, arb_req, out_valid, out_data, out_last, out_src, err_gnt, pkt_cnt
    );

    modport slave (
        output in_valid, in_data, in_last, arb_gnt, out_ready,
        input  in_ready, arb_req, out_valid, out_data, out_last, out_src, err_gnt, pkt_cnt
    );
endinterface

// File: rtl/gnt_lock_mux.sv
// Latches a one-hot arbiter grant, holds it for a whole packet (ended by last), and
// steers the granted port through a registered valid/ready output stage.
module gnt_lock_mux #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst,
    gnt_lock_mux_if.master bus
);
    localparam int SW = $clog2(N);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] gnt_idx;
    logic          gnt_onehot, gnt_multi;
    logic          err_d, out_free, xfer;
    logic [N-1:0]  arb_req_d, in_ready_d;

    logic          out_valid_q, out_last_q, err_q;
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_src_q;
    logic [15:0]   pkt_cnt_q;

    // OR-reduce the index so a legal one-hot grant decodes without a priority chain.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.arb_gnt[i]) gnt_idx = gnt_idx | SW'(i);
        end
        gnt_multi  = (bus.arb_gnt & (bus.arb_gnt - N'(1))) != '0;
        gnt_onehot = (bus.arb_gnt != '0) && !gnt_multi;
    end

    assign out_free = !out_valid_q || bus.out_ready;

    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves one unassigned and infers a latch.
        state_d    = state_q;
        sel_d      = sel_q;
        err_d      = 1'b0;
        xfer       = 1'b0;
        arb_req_d  = '0;
        in_ready_d = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    arb_req_d = bus.in_valid;
                    if (gnt_onehot && bus.in_valid[gnt_idx]) begin
                        sel_d   = gnt_idx;
                        state_d = LOCK;
                    end else if (gnt_multi) begin
                        err_d = 1'b1;
                    end
                end
                LOCK: begin
                    in_ready_d[sel_q] = out_free;
                    xfer              = bus.in_valid[sel_q] && out_free;
                    if (xfer && bus.in_last[sel_q]) state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[sel_q*W +: W];
                out_last_q  <= bus.in_last[sel_q];
                out_src_q   <= sel_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Packets are counted on input-side acceptance of the last beat, not on output drain.
            if (xfer && bus.in_last[sel_q]) pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign bus.arb_req   = arb_req_d;
    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign bus.err_gnt   = err_q;
    assign bus.pkt_cnt   = pkt_cnt_q;
endmodule

// File: tb/tb_gnt_lock_mux.sv
// Directed bench for gnt_lock_mux: a vector table for single-cycle behaviour plus
// hand-written sequences for backpressure, mid-packet reset and counter wrap.
module tb_gnt_lock_mux;
    localparam int N = 8;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gnt_lock_mux_if #(.N(N), .W(W)) bus ();

    gnt_lock_mux #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] gnt_man;
    logic [7:0] beat;
    logic       auto_arb;

    // Each port drives a data word that encodes its own index and the current beat number.
    function automatic logic [31:0] pdata(int p, int b);
        return 32'hA000_0000 + 32'(p) * 32'h100 + 32'(b);
    endfunction

    always_comb begin
        bus.in_data = '0;
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = pdata(i, int'(beat));
    end

    // Manual grant for directed cases; lowest-index-first arbiter for the streaming run.
    always_comb begin
        if (auto_arb) bus.arb_gnt = bus.arb_req & (~bus.arb_req + 8'd1);
        else          bus.arb_gnt = gnt_man;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [7:0]  vld, lst, gnt;
        logic        ordy;
        logic [7:0]  beat;
        logic [7:0]  req, rdy;
        logic        ov, ol;
        logic [2:0]  os;
        logic [31:0] od;
        logic        chk_od;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic [7:0] vld, logic [7:0] lst, logic [7:0] gnt,
                                logic ordy, logic [7:0] b, logic [7:0] req, logic [7:0] rdy,
                                logic ov, logic ol, logic [2:0] os, logic [31:0] od,
                                logic chk_od, logic err, logic [15:0] cnt);
        vec_t v;
        v.rst = r;     v.vld = vld;  v.lst = lst; v.gnt = gnt;
        v.ordy = ordy; v.beat = b;   v.req = req; v.rdy = rdy;
        v.ov = ov;     v.ol = ol;    v.os = os;   v.od = od;
        v.chk_od = chk_od; v.err = err; v.cnt = cnt;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic drive(input logic r, input logic [7:0] vld, input logic [7:0] lst,
                         input logic [7:0] gnt, input logic ordy, input logic [7:0] b);
        rst           = r;
        bus.in_valid  = vld;
        bus.in_last   = lst;
        gnt_man       = gnt;
        bus.out_ready = ordy;
        beat          = b;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic ol, input logic [2:0] os,
                             input logic [31:0] od, input logic [15:0] cnt);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        if (ov) begin
            check({tag, ".out_data"}, bus.out_data, od);
            check({tag, ".out_last"}, 32'(bus.out_last), 32'(ol));
            check({tag, ".out_src"},  32'(bus.out_src), 32'(os));
        end
        check({tag, ".pkt_cnt"}, 32'(bus.pkt_cnt), 32'(cnt));
    endtask

    logic [15:0] exp_cnt;

    initial begin
        auto_arb = 1'b0;
        drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 8'd0);
        tick();

        // Cols: rst vld lst gnt ordy beat | req rdy ov ol os od chk_od err cnt
        vecs.push_back(mk(1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0, 32'h0, 1, 0, 0));
        // Single 4-beat packet on port 2.
        vecs.push_back(mk(0, 8'h04, 8'h00, 8'h04, 1, 0, 8'h04, 8'h00, 0, 0, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h04, 8'h00, 8'h00, 1, 0, 8'h00, 8'h04, 1, 0, 2, pdata(2, 0), 1, 0, 0));
        vecs.push_back(mk(0, 8'h04, 8'h00, 8'h00, 1, 1, 8'h00, 8'h04, 1, 0, 2, pdata(2, 1), 1, 0, 0));
        vecs.push_back(mk(0, 8'h04, 8'h00, 8'h00, 1, 2, 8'h00, 8'h04, 1, 0, 2, pdata(2, 2), 1, 0, 0));
        vecs.push_back(mk(0, 8'h04, 8'h04, 8'h00, 1, 3, 8'h00, 8'h04, 1, 1, 2, pdata(2, 3), 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0, 32'h0, 0, 0, 1));
        // Illegal multi-bit grant, then a legal single-beat lock on port 0.
        vecs.push_back(mk(0, 8'h03, 8'h00, 8'h03, 1, 0, 8'h03, 8'h00, 0, 0, 0, 32'h0, 0, 1, 1));
        vecs.push_back(mk(0, 8'h03, 8'h00, 8'h01, 1, 0, 8'h03, 8'h00, 0, 0, 0, 32'h0, 0, 0, 1));
        vecs.push_back(mk(0, 8'h03, 8'h01, 8'h00, 1, 0, 8'h00, 8'h01, 1, 1, 0, pdata(0, 0), 1, 0, 2));
        // Grant to a port that is not requesting: no lock, no error.
        vecs.push_back(mk(0, 8'h02, 8'h00, 8'h04, 1, 0, 8'h02, 8'h00, 0, 0, 0, 32'h0, 0, 0, 2));
        vecs.push_back(mk(0, 8'h02, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 0, 0, 32'h0, 0, 0, 2));
        // Port 1 locked against competing port 5; port 1 stalls mid-packet.
        vecs.push_back(mk(0, 8'h22, 8'h00, 8'h02, 1, 0, 8'h22, 8'h00, 0, 0, 0, 32'h0, 0, 0, 2));
        vecs.push_back(mk(0, 8'h22, 8'h00, 8'h20, 1, 0, 8'h00, 8'h02, 1, 0, 1, pdata(1, 0), 1, 0, 2));
        vecs.push_back(mk(0, 8'h22, 8'h00, 8'h20, 1, 1, 8'h00, 8'h02, 1, 0, 1, pdata(1, 1), 1, 0, 2));
        vecs.push_back(mk(0, 8'h20, 8'h00, 8'h20, 1, 2, 8'h00, 8'h02, 0, 0, 0, 32'h0, 0, 0, 2));
        vecs.push_back(mk(0, 8'h22, 8'h02, 8'h20, 1, 2, 8'h00, 8'h02, 1, 1, 1, pdata(1, 2), 1, 0, 3));
        vecs.push_back(mk(0, 8'h20, 8'h00, 8'h20, 1, 0, 8'h20, 8'h00, 0, 0, 0, 32'h0, 0, 0, 3));
        vecs.push_back(mk(0, 8'h20, 8'h20, 8'h00, 1, 0, 8'h00, 8'h20, 1, 1, 5, pdata(5, 0), 1, 0, 4));

        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("v%0d", k);
            drive(vecs[k].rst, vecs[k].vld, vecs[k].lst, vecs[k].gnt, vecs[k].ordy, vecs[k].beat);
            #2;
            check({tag, ".arb_req"},  32'(bus.arb_req),  32'(vecs[k].req));
            check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(vecs[k].rdy));
            tick();
            check({tag, ".err_gnt"}, 32'(bus.err_gnt), 32'(vecs[k].err));
            check_out(tag, vecs[k].ov, vecs[k].ol, vecs[k].os, vecs[k].od, vecs[k].cnt);
            if (vecs[k].chk_od && !vecs[k].ov) check({tag, ".out_data"}, bus.out_data, vecs[k].od);
        end

        // Backpressure: freeze the output for three cycles in the middle of a port-3 packet.
        drive(0, 8'h08, 8'h00, 8'h08, 1, 0);
        #2 check("bp.req", 32'(bus.arb_req), 32'h08);
        tick();
        drive(0, 8'h08, 8'h00, 8'h00, 1, 0);
        #2 check("bp.rdy0", 32'(bus.in_ready), 32'h08);
        tick();
        check_out("bp.b0", 1, 0, 3, pdata(3, 0), 16'd4);
        beat = 8'd1;
        tick();
        check_out("bp.b1", 1, 0, 3, pdata(3, 1), 16'd4);
        bus.out_ready = 1'b0;
        beat = 8'd2;
        for (int c = 0; c < 3; c++) begin
            #2 check($sformatf("bp.hold%0d.rdy", c), 32'(bus.in_ready), 32'h00);
            tick();
            check_out($sformatf("bp.hold%0d", c), 1, 0, 3, pdata(3, 1), 16'd4);
        end
        bus.out_ready = 1'b1;
        #2 check("bp.resume.rdy", 32'(bus.in_ready), 32'h08);
        tick();
        check_out("bp.b2", 1, 0, 3, pdata(3, 2), 16'd4);
        beat = 8'd3;
        bus.in_last = 8'h08;
        tick();
        check_out("bp.b3", 1, 1, 3, pdata(3, 3), 16'd5);
        drive(0, 8'h00, 8'h00, 8'h00, 1, 0);
        tick();
        check_out("bp.drain", 0, 0, 0, 32'h0, 16'd5);

        // Reset after two of four beats on port 4.
        drive(0, 8'h10, 8'h00, 8'h10, 1, 0);
        tick();
        drive(0, 8'h10, 8'h00, 8'h00, 1, 0);
        tick();
        beat = 8'd1;
        tick();
        check_out("rs.pre", 1, 0, 4, pdata(4, 1), 16'd5);
        drive(1, 8'h10, 8'h00, 8'h00, 1, 2);
        #2;
        check("rs.req_in_rst", 32'(bus.arb_req),  32'h00);
        check("rs.rdy_in_rst", 32'(bus.in_ready), 32'h00);
        tick();
        check("rs.out_valid", 32'(bus.out_valid), 32'h0);
        check("rs.out_data",  bus.out_data,       32'h0);
        check("rs.pkt_cnt",   32'(bus.pkt_cnt),   32'h0);
        drive(0, 8'h10, 8'h00, 8'h10, 1, 0);
        #2;
        check("rs.req_after", 32'(bus.arb_req),  32'h10);
        check("rs.rdy_after", 32'(bus.in_ready), 32'h00);
        tick();
        drive(0, 8'h10, 8'h10, 8'h00, 1, 0);
        #2 check("rs.relock.rdy", 32'(bus.in_ready), 32'h10);
        tick();
        check_out("rs.relock", 1, 1, 4, pdata(4, 0), 16'd1);

        // Back-to-back single-beat packets: strict IDLE/LOCK alternation.
        auto_arb = 1'b1;
        exp_cnt  = 16'd1;
        drive(0, 8'h01, 8'h01, 8'h00, 1, 0);
        for (int p = 0; p < 100; p++) begin
            #2;
            check($sformatf("ss%0d.idle_req", p), 32'(bus.arb_req),  32'h01);
            check($sformatf("ss%0d.idle_rdy", p), 32'(bus.in_ready), 32'h00);
            tick();
            #2 check($sformatf("ss%0d.lock_rdy", p), 32'(bus.in_ready), 32'h01);
            tick();
            exp_cnt = exp_cnt + 16'd1;
            check_out($sformatf("ss%0d", p), 1, 1, 0, pdata(0, 0), exp_cnt);
        end

        // Preload the counter near its limit, then stream across the wrap.
        bus.in_valid = 8'h00;
        tick();
        force dut.pkt_cnt_q = 16'hFFFD;
        #1;
        release dut.pkt_cnt_q;
        exp_cnt = 16'hFFFD;
        bus.in_valid = 8'h01;
        for (int p = 0; p < 4; p++) begin
            #1 check($sformatf("wr%0d.idle_rdy", p), 32'(bus.in_ready), 32'h00);
            tick();
            #1 check($sformatf("wr%0d.lock_rdy", p), 32'(bus.in_ready), 32'h01);
            tick();
            exp_cnt = exp_cnt + 16'd1;
            check_out($sformatf("wr%0d", p), 1, 1, 0, pdata(0, 0), exp_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
